// File: rtl/debounce_toggle_ctrl.sv
// ---------------------------------------------------------------------------
// debounce_toggle_ctrl
//
// Purpose:
//   Cleans up a raw, possibly bouncing push-button or switch input before it
//   reaches the D/T flip-flop stage. The input passes through a synchronizer
//   chain and then a stability counter. A 4-state FSM accepts a new level
//   only after the synced input has held steady long enough. The block
//   produces a clean level, one-cycle rise/fall strobes and a toggle bit.
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst         in   1  synchronous, active-high reset
//   btn_in      in   1  raw asynchronous input, may bounce
//   enable      in   1  1 = qualify input, 0 = abort any pending qualification
//   level_out   out  1  debounced level
//   rise_pulse  out  1  one-cycle strobe on an accepted 0->1
//   fall_pulse  out  1  one-cycle strobe on an accepted 1->0
//   toggle_q    out  1  flips on every accepted rise (T-flop behaviour)
//   busy        out  1  high while a new level is being qualified
// ---------------------------------------------------------------------------
module debounce_toggle_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic enable,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic toggle_q,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   toggle_q_q, toggle_d;
    logic                   busy_q, busy_d;
    logic                   sync;

    // The oldest stage of the chain is the only safe copy of btn_in.
    assign sync   = sync_q[SYNC_STAGES-1];
    // The chain shifts every cycle, whether or not enable is set.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};

    // Next-state logic. A WAIT state returns to the IDLE state of the
    // current level when the synced input disagrees or enable drops.
    // The counter saturates at CNT_LAST because reaching it either accepts
    // the level or aborts, so it never wraps.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        toggle_d = toggle_q_q;

        unique case (state_q)
            IDLE_LOW: begin
                if (sync && enable) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync || !enable) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE_HIGH;
                    level_d  = 1'b1;
                    rise_d   = 1'b1;
                    toggle_d = ~toggle_q_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!sync && enable) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync || !enable) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    end

    // All state and outputs are registered, so nothing is combinational
    // from btn_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE_LOW;
            sync_q     <= '0;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            toggle_q_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            toggle_q_q <= toggle_d;
            busy_q     <= busy_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign toggle_q   = toggle_q_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_debounce_toggle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_debounce_toggle_ctrl
//
// Purpose:
//   Directed bench for debounce_toggle_ctrl at its default parameters.
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at
//   that same point. Strobes are counted on every cycle so the bench can
//   detect extra or missing pulses.
// ---------------------------------------------------------------------------
module tb_debounce_toggle_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic enable;
    logic level_out;
    logic rise_pulse;
    logic fall_pulse;
    logic toggle_q;
    logic busy;

    int checks = 0;
    int errors = 0;
    int rise_count = 0;
    int fall_count = 0;
    int rise_snap;
    int fall_snap;

    debounce_toggle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .enable     (enable),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .toggle_q   (toggle_q),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Counts one comparison. Reports it if the observed value differs from
    // the expected value.
    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic b, input logic e);
        rst    = r;
        btn_in = b;
        enable = e;
    endtask

    // Advances one clock and samples just after the edge. The two strobes
    // must never be high in the same cycle.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rise_pulse === 1'b1) rise_count++;
            if (fall_pulse === 1'b1) fall_count++;
            if (rise_pulse === 1'b1 && fall_pulse === 1'b1)
                check_output("pulse_exclusive", 1, 0);
        end
    endtask

    initial begin
        // Reset with the button released.
        apply_stimulus(1'b1, 1'b0, 1'b1);
        tick(3);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("rst_level", level_out, 0);
        check_output("rst_rise", rise_pulse, 0);
        check_output("rst_fall", fall_pulse, 0);
        check_output("rst_toggle", toggle_q, 0);
        check_output("rst_busy", busy, 0);
        tick(2);

        // Short press of 5 cycles: busy rises, but no level is accepted.
        rise_snap = rise_count;
        btn_in = 1'b1;
        tick(5);
        check_output("short_busy", busy, 1);
        btn_in = 1'b0;
        tick(10);
        check_output("short_busy_end", busy, 0);
        check_output("short_level", level_out, 0);
        check_output("short_toggle", toggle_q, 0);
        check_output("short_rises", rise_count - rise_snap, 0);

        // Clean press: the level is accepted 18 edges after the first edge.
        rise_snap = rise_count;
        btn_in = 1'b1;
        tick(18);
        check_output("press_busy_e17", busy, 1);
        check_output("press_level_e17", level_out, 0);
        tick(1);
        check_output("press_level_e18", level_out, 1);
        check_output("press_rise_e18", rise_pulse, 1);
        check_output("press_busy_e18", busy, 0);
        tick(1);
        check_output("press_rise_e19", rise_pulse, 0);
        check_output("press_toggle", toggle_q, 1);
        check_output("press_rises", rise_count - rise_snap, 1);

        // Release: a fall strobe is produced and toggle_q is left unchanged.
        fall_snap = fall_count;
        btn_in = 1'b0;
        tick(18);
        check_output("rel_level_e17", level_out, 1);
        tick(1);
        check_output("rel_level_e18", level_out, 0);
        check_output("rel_fall_e18", fall_pulse, 1);
        tick(1);
        check_output("rel_fall_e19", fall_pulse, 0);
        check_output("rel_toggle", toggle_q, 1);
        check_output("rel_falls", fall_count - fall_snap, 1);

        // Bounce 1,0,1,1,0,1 followed by a stable 1: one rise strobe,
        // timed from the final 0->1.
        rise_snap = rise_count;
        btn_in = 1'b1; tick(1);
        btn_in = 1'b0; tick(1);
        btn_in = 1'b1; tick(1);
        btn_in = 1'b1; tick(1);
        btn_in = 1'b0; tick(1);
        btn_in = 1'b1;
        tick(18);
        check_output("bounce_level_e17", level_out, 0);
        check_output("bounce_rises_e17", rise_count - rise_snap, 0);
        tick(1);
        check_output("bounce_level_e18", level_out, 1);
        check_output("bounce_rise_e18", rise_pulse, 1);
        check_output("bounce_toggle", toggle_q, 0);
        tick(5);
        check_output("bounce_rises", rise_count - rise_snap, 1);

        // Input toggling every cycle: the level stays at 1 and no fall is seen.
        fall_snap = fall_count;
        for (int i = 0; i < 40; i++) begin
            btn_in = ~btn_in;
            tick(1);
        end
        btn_in = 1'b1;
        tick(5);
        check_output("chatter_level", level_out, 1);
        check_output("chatter_falls", fall_count - fall_snap, 0);

        // Return to level 0, then assert reset while WAIT_HIGH has cnt=10.
        btn_in = 1'b0;
        tick(25);
        check_output("pre_rst_level", level_out, 0);
        btn_in = 1'b1;
        tick(13);
        check_output("mid_rst_busy_before", busy, 1);
        rst = 1'b1;
        tick(1);
        check_output("mid_rst_level", level_out, 0);
        check_output("mid_rst_busy", busy, 0);
        check_output("mid_rst_toggle", toggle_q, 0);
        check_output("mid_rst_rise", rise_pulse, 0);
        check_output("mid_rst_fall", fall_pulse, 0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        tick(5);

        // Drop enable while WAIT_HIGH has cnt=10: abort with no pulse.
        rise_snap = rise_count;
        btn_in = 1'b1;
        tick(13);
        check_output("en_busy_before", busy, 1);
        enable = 1'b0;
        tick(1);
        check_output("en_abort_busy", busy, 0);
        check_output("en_abort_level", level_out, 0);
        tick(30);
        check_output("en_hold_level", level_out, 0);
        check_output("en_hold_busy", busy, 0);
        check_output("en_hold_rises", rise_count - rise_snap, 0);

        // Re-enable with sync already 1: qualification takes 16 edges after
        // WAIT_HIGH is entered.
        enable = 1'b1;
        tick(16);
        check_output("reen_level_e16", level_out, 0);
        tick(1);
        check_output("reen_level_e17", level_out, 1);
        check_output("reen_toggle", toggle_q, 1);
        check_output("reen_rises", rise_count - rise_snap, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
